// File: rtl/multicycle_control_unit_if.sv
// Opcode/handshake inputs and datapath control outputs of the multi-cycle MIPS control unit.
// master = control unit side, slave = datapath side.
interface multicycle_control_unit_if #(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
);
    logic [OPC_W-1:0]   Opc;
    logic               MemReady;
    logic               PCWrite;
    logic               Branch;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemToReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSrc;
    logic [3:0]         StateOut;
    logic               Illegal;
    logic [CNT_W-1:0]   InstrCount;

    modport master (
        input  Opc, MemReady,
        output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, StateOut, Illegal, InstrCount
    );

    modport slave (
        output Opc, MemReady,
        input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, StateOut, Illegal, InstrCount
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS Moore control FSM with retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap (Illegal=1) instead of retiring as NOPs.
module multicycle_control_unit #(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    multicycle_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPE_EX = 4'd7,
        RTYPE_WB = 4'd8,
        BEQ_EX   = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        JUMP_EX  = 4'd12,
        TRAP     = 4'd13
    } state_e;

    // Opcodes are zero-extended, so any set upper bit prevents a match.
    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b010);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   instrCount_q, instrCount_d;
    logic               retire;

    logic               pcWrite, branch, iorD, memRead, memWrite, irWrite;
    logic               regDst, memToReg, regWrite, aluSrcA;
    logic [1:0]         aluSrcB, pcSrc;
    logic [ALUOP_W-1:0] aluOp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            instrCount_q <= '0;
        end else begin
            state_q      <= state_d;
            instrCount_q <= instrCount_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = FETCH;
            FETCH:    if (bus.MemReady) state_d = DECODE;
            DECODE: begin
                if ((bus.Opc == OP_LW) || (bus.Opc == OP_SW)) state_d = MEMADR;
                else if (bus.Opc == OP_R)                     state_d = RTYPE_EX;
                else if (bus.Opc == OP_BEQ)                   state_d = BEQ_EX;
                else if (bus.Opc == OP_ADDI)                  state_d = ADDI_EX;
                else if (bus.Opc == OP_J)                     state_d = JUMP_EX;
                else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = TRAP;
`else
                    state_d = FETCH;
`endif
                end
            end
            MEMADR:   state_d = (bus.Opc == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    if (bus.MemReady) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWR:    if (bus.MemReady) state_d = FETCH;
            RTYPE_EX: state_d = RTYPE_WB;
            RTYPE_WB: state_d = FETCH;
            BEQ_EX:   state_d = FETCH;
            ADDI_EX:  state_d = ADDI_WB;
            ADDI_WB:  state_d = FETCH;
            JUMP_EX:  state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = IDLE;
        endcase
    end

    // A stall in FETCH re-enters FETCH but is not a retirement.
    assign retire       = (state_d == FETCH) && (state_q != IDLE) && (state_q != FETCH);
    assign instrCount_d = retire ? instrCount_q + CNT_W'(1) : instrCount_q;

    always_comb begin
        pcWrite  = 1'b0;
        branch   = 1'b0;
        iorD     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        irWrite  = 1'b0;
        regDst   = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = 2'b00;
        aluOp    = ALU_ADD;
        pcSrc    = 2'b00;
        case (state_q)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = bus.MemReady;
                pcWrite = bus.MemReady;
            end
            DECODE: begin
                aluSrcB = 2'b11;
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            RTYPE_EX: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            RTYPE_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            BEQ_EX: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_SUB;
                branch  = 1'b1;
                pcSrc   = 2'b01;
            end
            ADDI_EX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            ADDI_WB: begin
                regWrite = 1'b1;
            end
            JUMP_EX: begin
                pcWrite = 1'b1;
                pcSrc   = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite    = pcWrite;
    assign bus.Branch     = branch;
    assign bus.IorD       = iorD;
    assign bus.MemRead    = memRead;
    assign bus.MemWrite   = memWrite;
    assign bus.IRWrite    = irWrite;
    assign bus.RegDst     = regDst;
    assign bus.MemToReg   = memToReg;
    assign bus.RegWrite   = regWrite;
    assign bus.ALUSrcA    = aluSrcA;
    assign bus.ALUSrcB    = aluSrcB;
    assign bus.ALUOp      = aluOp;
    assign bus.PCSrc      = pcSrc;
    assign bus.StateOut   = state_q;
    assign bus.InstrCount = instrCount_q;

`ifdef ILLEGAL_TRAP_EN
    assign bus.Illegal = (state_q == TRAP);
`else
    assign bus.Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table plus scoreboard, with a
// second 4-bit-counter instance sharing the stimulus to exercise counter wrap.
module tb_multicycle_control_unit;

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5,  S_MEMWR = 4'd6,   S_RTEX = 4'd7,
                           S_RTWB = 4'd8,  S_BEQ = 4'd9,    S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                           S_JUMP = 4'd12, S_TRAP = 4'd13;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;

    typedef struct {
        logic [5:0]  opc;
        logic        rdy;
        logic [3:0]  state;
        logic [31:0] count;
    } vec_t;

    typedef struct {
        logic [3:0]  state;
        logic [17:0] ctrl;
        logic [31:0] count;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs[$];
    exp_t sb[$];

    multicycle_control_unit_if #(.OPC_W(6), .ALUOP_W(3), .CNT_W(32)) bus  ();
    multicycle_control_unit_if #(.OPC_W(6), .ALUOP_W(3), .CNT_W(4))  bus4 ();

    assign bus4.Opc      = bus.Opc;
    assign bus4.MemReady = bus.MemReady;

    multicycle_control_unit #(.OPC_W(6), .ALUOP_W(3), .CNT_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.master)
    );

    multicycle_control_unit #(.OPC_W(6), .ALUOP_W(3), .CNT_W(4)) dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected control bundle per state, in the order used by dutCtrl below.
    function automatic logic [17:0] expectedCtrl(input logic [3:0] st, input logic rdy);
        logic pcW, br, iod, mRd, mWr, irW, rDst, m2r, rW, srcA, ill;
        logic [1:0] srcB, pcS;
        logic [2:0] op;
        {pcW, br, iod, mRd, mWr, irW, rDst, m2r, rW, srcA, ill} = '0;
        srcB = 2'b00; pcS = 2'b00; op = 3'b000;
        case (st)
            S_FETCH:  begin mRd = 1'b1; srcB = 2'b01; irW = rdy; pcW = rdy; end
            S_DECODE: srcB = 2'b11;
            S_MEMADR: begin srcA = 1'b1; srcB = 2'b10; end
            S_MEMRD:  begin mRd = 1'b1; iod = 1'b1; end
            S_MEMWB:  begin rW = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mWr = 1'b1; iod = 1'b1; end
            S_RTEX:   begin srcA = 1'b1; op = 3'b001; end
            S_RTWB:   begin rW = 1'b1; rDst = 1'b1; end
            S_BEQ:    begin srcA = 1'b1; op = 3'b010; br = 1'b1; pcS = 2'b01; end
            S_ADDIEX: begin srcA = 1'b1; srcB = 2'b10; end
            S_ADDIWB: rW = 1'b1;
            S_JUMP:   begin pcW = 1'b1; pcS = 2'b10; end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   ill = 1'b1;
`endif
            default: ;
        endcase
        return {pcW, br, iod, mRd, mWr, irW, rDst, m2r, rW, srcA, srcB, op, pcS, ill};
    endfunction

    function automatic logic [17:0] dutCtrl();
        return {bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.RegDst, bus.MemToReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                bus.PCSrc, bus.Illegal};
    endfunction

    function automatic logic [17:0] dut4Ctrl();
        return {bus4.PCWrite, bus4.Branch, bus4.IorD, bus4.MemRead, bus4.MemWrite, bus4.IRWrite,
                bus4.RegDst, bus4.MemToReg, bus4.RegWrite, bus4.ALUSrcA, bus4.ALUSrcB, bus4.ALUOp,
                bus4.PCSrc, bus4.Illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input logic [5:0] opc, input logic rdy, input logic [3:0] st,
                          input logic [31:0] cnt);
        vec_t v;
        v.opc = opc; v.rdy = rdy; v.state = st; v.count = cnt;
        vecs.push_back(v);
    endtask

    // Drives one cycle's inputs (called at a falling edge) and queues what must be seen.
    task automatic applyStimulus(input logic [5:0] opc, input logic rdy, input logic [3:0] st,
                                 input logic [31:0] cnt);
        exp_t e;
        bus.Opc      = opc;
        bus.MemReady = rdy;
        e.state = st;
        e.ctrl  = expectedCtrl(st, rdy);
        e.count = cnt;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        #2;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            check("state",  32'(bus.StateOut),   32'(e.state));
            check("ctrl",   32'(dutCtrl()),      32'(e.ctrl));
            check("count",  bus.InstrCount,      e.count);
            check("ctrl4",  32'(dut4Ctrl()),     32'(e.ctrl));
            check("count4", 32'(bus4.InstrCount), 32'(e.count[3:0]));
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [5:0] opc, input logic rdy, input logic [3:0] st,
                        input logic [31:0] cnt);
        applyStimulus(opc, rdy, st, cnt);
        checkOutput();
    endtask

    task automatic resetCheck();
        #1;
        check("rst_state", 32'(bus.StateOut), 32'(S_IDLE));
        check("rst_ctrl",  32'(dutCtrl()),    32'd0);
        check("rst_count", bus.InstrCount,    32'd0);
        check("rst_count4", 32'(bus4.InstrCount), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.Opc      = 6'd0;
        bus.MemReady = 1'b0;

        // lw, all ready
        addVec(OP_LW, 1, S_IDLE, 0);   addVec(OP_LW, 1, S_FETCH, 0);  addVec(OP_LW, 1, S_DECODE, 0);
        addVec(OP_LW, 1, S_MEMADR, 0); addVec(OP_LW, 1, S_MEMRD, 0);  addVec(OP_LW, 1, S_MEMWB, 0);
        // sw with three wait cycles in MEMWR
        addVec(OP_SW, 1, S_FETCH, 1);  addVec(OP_SW, 1, S_DECODE, 1); addVec(OP_SW, 1, S_MEMADR, 1);
        addVec(OP_SW, 0, S_MEMWR, 1);  addVec(OP_SW, 0, S_MEMWR, 1);  addVec(OP_SW, 0, S_MEMWR, 1);
        addVec(OP_SW, 1, S_MEMWR, 1);
        // R, beq, addi, j back to back (MemReady low in beq DECODE must be ignored)
        addVec(OP_R, 1, S_FETCH, 2);   addVec(OP_R, 1, S_DECODE, 2);  addVec(OP_R, 1, S_RTEX, 2);
        addVec(OP_R, 1, S_RTWB, 2);
        addVec(OP_BEQ, 1, S_FETCH, 3); addVec(OP_BEQ, 0, S_DECODE, 3); addVec(OP_BEQ, 1, S_BEQ, 3);
        addVec(OP_ADDI, 1, S_FETCH, 4); addVec(OP_ADDI, 1, S_DECODE, 4);
        addVec(OP_ADDI, 1, S_ADDIEX, 4); addVec(OP_ADDI, 1, S_ADDIWB, 4);
        addVec(OP_J, 1, S_FETCH, 5);   addVec(OP_J, 1, S_DECODE, 5);  addVec(OP_J, 1, S_JUMP, 5);
        // FETCH stalled two cycles, then an R-type
        addVec(OP_R, 0, S_FETCH, 6);   addVec(OP_R, 0, S_FETCH, 6);   addVec(OP_R, 1, S_FETCH, 6);
        addVec(OP_R, 1, S_DECODE, 6);  addVec(OP_R, 1, S_RTEX, 6);    addVec(OP_R, 1, S_RTWB, 6);
        // lw with one MEMRD wait; MemReady low in MEMWB is ignored
        addVec(OP_LW, 1, S_FETCH, 7);  addVec(OP_LW, 1, S_DECODE, 7); addVec(OP_LW, 1, S_MEMADR, 7);
        addVec(OP_LW, 0, S_MEMRD, 7);  addVec(OP_LW, 1, S_MEMRD, 7);  addVec(OP_LW, 0, S_MEMWB, 7);
        addVec(OP_R, 1, S_FETCH, 8);

        @(negedge clk);
        resetCheck();
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) step(vecs[i].opc, vecs[i].rdy, vecs[i].state, vecs[i].count);

        $display("[TB] counter wrap: 17 R-type instructions");
        rst_n = 1'b0;
        resetCheck();
        @(negedge clk);
        rst_n = 1'b1;
        step(OP_R, 1, S_IDLE, 0);
        for (int i = 0; i < 17; i++) begin
            step(OP_R, 1, S_FETCH, 32'(i));
            step(OP_R, 1, S_DECODE, 32'(i));
            step(OP_R, 1, S_RTEX, 32'(i));
            step(OP_R, 1, S_RTWB, 32'(i));
        end

        $display("[TB] asynchronous reset during RTYPE_EX");
        step(OP_R, 1, S_FETCH, 17);
        step(OP_R, 1, S_DECODE, 17);
        #1;
        check("pre_rst_state",  32'(bus.StateOut),    32'(S_RTEX));
        check("pre_rst_count",  bus.InstrCount,       32'd17);
        check("pre_rst_count4", 32'(bus4.InstrCount), 32'd1);
        rst_n = 1'b0;
        resetCheck();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] unknown opcode 111111");
        step(OP_BAD, 1, S_IDLE, 0);
        step(OP_BAD, 1, S_FETCH, 0);
        step(OP_BAD, 1, S_DECODE, 0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) step(OP_BAD, 1, S_TRAP, 0);
`else
        step(OP_R, 1, S_FETCH, 1);
        step(OP_R, 1, S_DECODE, 1);
`endif

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation MIPS control unit: multi-cycle Moore FSM replacing the single-cycle opcode decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction.
- Drives datapath mux selects and write strobes, and waits on a memory-ready handshake.
- Also keeps a retired-instruction counter; sits between the instruction register opcode field and the shared-memory multi-cycle datapath.

Parameters:
- OPC_W, 6, opcode width; opcodes compared in the low 6 bits, upper bits must be 0 to match.
- ALUOP_W, 3, ALUOp width (>=3); codes zero-extended.
- CNT_W, 32, retired-instruction counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Opc  in  OPC_W  opcode from instruction register; sampled only in DECODE and MEMADR.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  PC load if ALU Zero.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register: 0=rt, 1=rd.
- MemToReg  out  1  writeback data: 0=ALUOut, 1=MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- ALUOp  out  ALUOP_W  000=add, 001=use funct, 010=sub.
- PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- StateOut  out  4  current state encoding.
- Illegal  out  1  illegal-opcode trap flag.
- InstrCount  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE(0), InstrCount=0, all outputs 0.
- Outputs not listed for a state are 0.
- Decodes are combinational from the state register. IRWrite and PCWrite in FETCH are additionally gated by MemReady.
- Encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPE_EX=7, RTYPE_WB=8, BEQ_EX=9, ADDI_EX=10, ADDI_WB=11, JUMP_EX=12, TRAP=13.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- IDLE -> FETCH unconditionally on the first edge after reset release.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=01, ALUOp=add, IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; -> DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcB=11, ALUOp=add.
  - Next state by Opc: lw/sw -> MEMADR; R -> RTYPE_EX; beq -> BEQ_EX; addi -> ADDI_EX; j -> JUMP_EX; other -> see Optional Feature.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1; holds until MemReady=1, then -> MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0; -> FETCH.
- MEMWR: MemWrite=1, IorD=1; holds until MemReady=1, then -> FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=001; -> RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1; -> FETCH.
- BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, Branch=1, PCSrc=01; -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, add; -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0; -> FETCH.
- JUMP_EX: PCWrite=1, PCSrc=10; -> FETCH.
- Instruction latency (MemReady always 1):
  - lw 5 cycles; sw, R, addi 4 cycles; beq, j 3 cycles.
  - Each wait cycle adds 1.
- InstrCount:
  - Increments by 1 on every edge whose next state is FETCH from a non-IDLE state (retire).
  - Wraps modulo 2^CNT_W.
  - Never increments in IDLE or TRAP.
- MemReady is ignored outside FETCH/MEMRD/MEMWR.
- Reset mid-instruction: immediate return to IDLE, counter cleared, no partial strobes after Rst_n falls.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN
- Defined:
  - Unknown opcode in DECODE -> TRAP.
  - TRAP asserts Illegal=1 with all strobes 0 and holds until reset.
  - The instruction is not counted.
- Undefined:
  - Unknown opcode in DECODE -> FETCH as a NOP; counted as retired.
  - Illegal is tied 0; TRAP is unreachable.

Test Plan:
- Reset then lw (Opc=100011), MemReady=1: StateOut sequence 0,1,2,3,4,5,1. RegWrite=1 and MemToReg=1 only in MEMWB. InstrCount 0->1.
- sw with MemReady=0 for 3 cycles in MEMWR: MemWrite=1 and IorD=1 for 4 cycles, then FETCH. No RegWrite asserted. Count +1.
- R-type, beq, addi, j back-to-back with MemReady=1: total 4+3+4+3=14 cycles. ALUOp=001 in RTYPE_EX, 010 in BEQ_EX. PCSrc=10 with PCWrite=1 in JUMP_EX. InstrCount=4.
- FETCH with MemReady=0 for 2 cycles: IRWrite=PCWrite=0 while waiting, both 1 on the ready cycle, then DECODE.
- Opc=111111: with ILLEGAL_TRAP_EN, StateOut=13, Illegal=1, count unchanged for 10 cycles. Without the macro, returns to FETCH, Illegal=0, count +1.
- CNT_W=4, run 17 R-type instructions: InstrCount=1 (wrap). Assert Rst_n=0 during RTYPE_EX: outputs 0 and StateOut=0 immediately (async).
